// File: rtl/button_conditioner.sv
// Button front end: three raw active-low keys are synchronised, debounced with
// a stable-count filter and turned into one-cycle press pulses. Start is passed
// through as a pulse, pause drives a toggle level that finish_i clears, and
// slice adds hold-to-repeat behaviour through a small FSM.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_btn_n,
  input  logic pause_btn_n,
  input  logic slice_btn_n,
  input  logic finish_i,
  output logic start_o,
  output logic pause_o,
  output logic slice_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = (RC_MAX > 2) ? $clog2(RC_MAX) : 1;
  localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  // Channel index: 0 = start, 1 = pause, 2 = slice. Bit value 1 = released.
  localparam int CH_START = 0;
  localparam int CH_PAUSE = 1;
  localparam int CH_SLICE = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } slice_state_t;

  logic [2:0]       raw;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_p1;
  logic [2:0]       stable;
  logic [2:0]       stable_d;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       press;

  slice_state_t     slice_state;
  logic [RC_W-1:0]  rc;

  assign raw = {slice_btn_n, pause_btn_n, start_btn_n};

  // A press is the released->pressed transition of the debounced state,
  // observed one cycle after the state flips; outputs register it on the
  // following edge.
  assign press = stable_d & ~stable;

  // Two-flop synchroniser plus stable-count debounce for every channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0  <= '1;
      sync_p1  <= '1;
      stable   <= '1;
      stable_d <= '1;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      stable_d <= stable;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == stable[i]) begin
          // Any agreeing sample restarts the disagreement count.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_p1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Start pulse and pause toggle level; finish_i overrides a coincident toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_o <= 1'b0;
      pause_o <= 1'b0;
    end else begin
      start_o <= press[CH_START];
      if (finish_i) begin
        pause_o <= 1'b0;
      end else if (press[CH_PAUSE]) begin
        pause_o <= ~pause_o;
      end
    end
  end

  // Slice auto-repeat FSM: first pulse on press, one after the initial delay,
  // then one per repeat period until the debounced key is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice_state <= IDLE;
      rc          <= '0;
      slice_o     <= 1'b0;
    end else begin
      slice_o <= 1'b0;
      case (slice_state)
        IDLE: begin
          rc <= '0;
          if (press[CH_SLICE]) begin
            slice_o     <= 1'b1;
            slice_state <= DELAY;
          end
        end
        DELAY: begin
          if (stable[CH_SLICE]) begin
            slice_state <= IDLE;
            rc          <= '0;
          end else if (rc == DELAY_LAST) begin
            slice_o     <= 1'b1;
            rc          <= '0;
            slice_state <= REPEAT;
          end else begin
            rc <= rc + 1'b1;
          end
        end
        REPEAT: begin
          if (stable[CH_SLICE]) begin
            slice_state <= IDLE;
            rc          <= '0;
          end else if (rc == PERIOD_LAST) begin
            slice_o <= 1'b1;
            rc      <= '0;
          end else begin
            rc <= rc + 1'b1;
          end
        end
        default: begin
          slice_state <= IDLE;
          rc          <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: the stimulus process queues the
// output events it expects (kind, edge number, value) and an independent
// monitor records every output event and compares it against the queue head.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  localparam int K_START = 0;
  localparam int K_PAUSE = 1;
  localparam int K_SLICE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_btn_n = 1'b1;
  logic pause_btn_n = 1'b1;
  logic slice_btn_n = 1'b1;
  logic finish_i = 1'b0;
  logic start_o;
  logic pause_o;
  logic slice_o;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic pause_prev = 1'b0;

  typedef struct {
    int   kind;
    int   cycle;
    logic val;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_btn_n(start_btn_n),
    .pause_btn_n(pause_btn_n),
    .slice_btn_n(slice_btn_n),
    .finish_i(finish_i),
    .start_o(start_o),
    .pause_o(pause_o),
    .slice_o(slice_o)
  );

  function automatic string kname(int k);
    case (k)
      K_START: return "start";
      K_PAUSE: return "pause";
      default: return "slice";
    endcase
  endfunction

  task automatic expect_ev(int kind, int cycle, logic val);
    ev_t e;
    e.kind  = kind;
    e.cycle = cycle;
    e.val   = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(int kind, logic val);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got val=%0b at edge %0d, required no event", kname(kind), val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cycle != cyc || e.val !== val) begin
        n_fail++;
        $display("FAIL %s_event: got %s val=%0b at edge %0d, required %s val=%0b at edge %0d",
                 kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cycle);
      end
    end
  endtask

  task automatic check(string name, logic got, logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0b, required %0b", name, got, want);
    end
  endtask

  // Return at the falling edge just before rising edge e, so that inputs
  // driven now are first sampled at edge e.
  task automatic at_edge(int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  // Monitor: numbers rising edges and reports every output event.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (start_o === 1'b1) observe(K_START, 1'b1);
      if (pause_o !== pause_prev) begin
        observe(K_PAUSE, pause_o);
        pause_prev = pause_o;
      end
      if (slice_o === 1'b1) observe(K_SLICE, 1'b1);
    end
  end

  // Stimulus with hand-computed expectations (press latency = D + 2 edges).
  initial begin
    ev_t left;

    at_edge(3);
    check("reset_start_o", start_o, 1'b0);
    check("reset_pause_o", pause_o, 1'b0);
    check("reset_slice_o", slice_o, 1'b0);
    at_edge(4);
    rst_n = 1'b1;

    // Clean start press: low from edge 10 -> pulse at 16, nothing on release.
    at_edge(10);
    start_btn_n = 1'b0;
    expect_ev(K_START, 16, 1'b1);
    at_edge(60);
    start_btn_n = 1'b1;

    // Bounce: 3 low, 1 high, 2 low -> never reaches 4 disagreeing samples.
    at_edge(80);
    pause_btn_n = 1'b0;
    at_edge(83);
    pause_btn_n = 1'b1;
    at_edge(84);
    pause_btn_n = 1'b0;
    at_edge(86);
    pause_btn_n = 1'b1;
    // Two clean presses toggle pause up then down.
    at_edge(100);
    pause_btn_n = 1'b0;
    expect_ev(K_PAUSE, 106, 1'b1);
    at_edge(110);
    pause_btn_n = 1'b1;
    at_edge(130);
    pause_btn_n = 1'b0;
    expect_ev(K_PAUSE, 136, 1'b0);
    at_edge(140);
    pause_btn_n = 1'b1;

    // Auto-repeat: held 60 cycles from 200 -> 206, +20, then every 8;
    // the 266 pulse is suppressed because release is debounced at 265.
    at_edge(200);
    slice_btn_n = 1'b0;
    expect_ev(K_SLICE, 206, 1'b1);
    for (int i = 0; i < 5; i++) expect_ev(K_SLICE, 226 + 8 * i, 1'b1);
    at_edge(260);
    slice_btn_n = 1'b1;
    // Short press afterwards -> exactly one pulse.
    at_edge(290);
    slice_btn_n = 1'b0;
    expect_ev(K_SLICE, 296, 1'b1);
    at_edge(296);
    slice_btn_n = 1'b1;

    // Finish priority.
    at_edge(320);
    pause_btn_n = 1'b0;
    expect_ev(K_PAUSE, 326, 1'b1);
    at_edge(330);
    pause_btn_n = 1'b1;
    // pause=1, press pulse and finish together at 356 -> 0.
    at_edge(350);
    pause_btn_n = 1'b0;
    expect_ev(K_PAUSE, 356, 1'b0);
    at_edge(356);
    finish_i = 1'b1;
    at_edge(357);
    finish_i = 1'b0;
    at_edge(360);
    pause_btn_n = 1'b1;
    // pause=0, press pulse and finish together at 386 -> stays 0.
    at_edge(380);
    pause_btn_n = 1'b0;
    at_edge(386);
    finish_i = 1'b1;
    at_edge(387);
    finish_i = 1'b0;
    at_edge(390);
    pause_btn_n = 1'b1;
    // Finish alone clears a set pause level.
    at_edge(410);
    pause_btn_n = 1'b0;
    expect_ev(K_PAUSE, 416, 1'b1);
    at_edge(420);
    pause_btn_n = 1'b1;
    at_edge(430);
    finish_i = 1'b1;
    expect_ev(K_PAUSE, 430, 1'b0);
    at_edge(431);
    finish_i = 1'b0;

    // Simultaneous keys: all three respond on edge 456.
    at_edge(450);
    start_btn_n = 1'b0;
    pause_btn_n = 1'b0;
    slice_btn_n = 1'b0;
    expect_ev(K_START, 456, 1'b1);
    expect_ev(K_PAUSE, 456, 1'b1);
    expect_ev(K_SLICE, 456, 1'b1);
    at_edge(460);
    start_btn_n = 1'b1;
    pause_btn_n = 1'b1;
    slice_btn_n = 1'b1;

    // Reset in REPEAT with slice held and pause set.
    at_edge(500);
    slice_btn_n = 1'b0;
    expect_ev(K_SLICE, 506, 1'b1);
    expect_ev(K_SLICE, 526, 1'b1);
    expect_ev(K_SLICE, 534, 1'b1);
    at_edge(541);
    rst_n = 1'b0;
    #1;
    check("async_reset_start_o", start_o, 1'b0);
    check("async_reset_pause_o", pause_o, 1'b0);
    check("async_reset_slice_o", slice_o, 1'b0);
    expect_ev(K_PAUSE, 541, 1'b0);
    at_edge(546);
    rst_n = 1'b1;
    // Key still held: first sampled at 546 -> one fresh pulse at 552.
    expect_ev(K_SLICE, 552, 1'b1);
    at_edge(560);
    slice_btn_n = 1'b1;

    at_edge(600);
    while (exp_q.size() > 0) begin
      left = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_%s_event: got no event, required val=%0b at edge %0d",
               kname(left.kind), left.val, left.cycle);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
